nios2vga_control_out: RTL and testbench
=======================================

NIOS2VGA_CONTROL_OUT -- requirements
Module: nios2VGA_control_out

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of out_port, out_pulse and all register data fields.
REQ-002 Parameter RESET_VALUE, default 0: value of out_port after reset.
REQ-003 Parameter PULSE_LEN, default 4, range 1..255: out_pulse duration in clk cycles.
REQ-004 clk  input  1: single clock; all logic on its rising edge.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 address  input  3: Avalon-MM slave register select.
REQ-007 chipselect  input  1: slave select; writes are ignored when low.
REQ-008 write_n  input  1: active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-009 writedata  input  32: write data; only bits [DATA_WIDTH-1:0] are used.
REQ-010 readdata  output  32: registered read data, zero-extended.
REQ-011 out_port  output  DATA_WIDTH: registered control word to the VGA side.
REQ-012 out_valid  output  1: asserted while an out_port change is pending.
REQ-013 out_ack  input  1: VGA-side acknowledge of out_valid.
REQ-014 out_pulse  output  DATA_WIDTH: one-shot pulse lines.

Function
REQ-015 Register map: 0 DATA (read/write); 1 STATUS (read-only); 2 PULSE (write-only); 4 OUTSET (write-only); 5 OUTCLEAR (write-only); 3, 6, 7 reserved (writes ignored, reads return 0).
REQ-016 A DATA write loads out_port <= writedata[DATA_WIDTH-1:0] on the same clock edge.
REQ-017 An OUTSET write loads out_port <= out_port | writedata[DATA_WIDTH-1:0].
REQ-018 An OUTCLEAR write loads out_port <= out_port & ~writedata[DATA_WIDTH-1:0].
REQ-019 readdata updates every clock: DATA -> out_port; STATUS -> {30'b0, pulse_busy, out_valid}; all other addresses -> 0. Latency is 1 cycle from address to readdata.
REQ-020 out_valid is set on the edge after any write to DATA, OUTSET or OUTCLEAR, whether or not the value changes.
REQ-021 out_valid clears on the edge where out_ack=1 and no DATA/OUTSET/OUTCLEAR write occurs in the same cycle.
REQ-022 If out_ack=1 and a DATA/OUTSET/OUTCLEAR write occur in the same cycle, out_valid stays 1 (the new change wins).
REQ-023 out_ack while out_valid=0 has no effect.
REQ-024 The pulse FSM has two states: IDLE and ACTIVE. It holds an 8-bit down-counter cnt and a DATA_WIDTH-bit mask.
REQ-025 In IDLE, a PULSE write with a nonzero mask loads mask, sets cnt=PULSE_LEN and moves to ACTIVE.
REQ-026 In IDLE, a PULSE write with a zero mask is ignored and the FSM stays in IDLE.
REQ-027 In ACTIVE, out_pulse = mask and cnt decrements each cycle; when cnt reaches 1, the next edge goes to IDLE.
REQ-028 out_pulse is therefore high for exactly PULSE_LEN cycles, starting the cycle after the write.
REQ-029 A nonzero PULSE write in ACTIVE replaces mask and reloads cnt=PULSE_LEN (restart). A zero-mask write in ACTIVE aborts: the FSM goes to IDLE on the next edge.
REQ-030 pulse_busy = (state == ACTIVE). out_pulse = 0 in IDLE.
REQ-031 A PULSE write has no effect on out_port or out_valid.

Reset
REQ-032 Asserting reset_n=0 immediately and asynchronously forces: out_port=RESET_VALUE, out_valid=0, readdata=0, FSM=IDLE, cnt=0, mask=0, out_pulse=0. This applies mid-pulse and mid-handshake.
REQ-033 On reset_n deassertion, the first active edge behaves as a normal cycle; there are no extra wait states.

Verification
REQ-034 Write DATA=0xA5, then read DATA -> out_port=0xA5 one cycle after the write; readdata=0x000000A5; out_valid=1.
REQ-035 With out_port=0xA5: OUTSET 0x0A -> 0xAF; OUTCLEAR 0x81 -> 0x2E; out_valid stays 1 with out_ack held 0.
REQ-036 out_ack=1 for one cycle -> out_valid=0 the next cycle. Write DATA in the same cycle as out_ack -> out_valid remains 1.
REQ-037 PULSE write 0x03 with PULSE_LEN=4 -> out_pulse=0x03 for exactly 4 cycles, then 0x00; STATUS bit1=1 throughout.
REQ-038 PULSE 0x01, then PULSE 0x02 two cycles later -> out_pulse=0x02 for 4 more cycles. PULSE 0x00 while ACTIVE -> out_pulse=0 next cycle.
REQ-039 Assert reset_n mid-pulse with out_valid=1 -> all outputs reset asynchronously, before the next clk edge. Reserved-address reads return 0; reserved-address writes change nothing.

Source files
------------

// File: rtl/nios2vga_control_out_if.sv
// nios2vga_control_out_if: Avalon-MM register bus plus VGA-side control word, handshake and pulse lines.
//   slave  modport: the control block (takes the bus, drives out_port/out_valid/out_pulse/readdata)
//   master modport: the Nios side and VGA side seen together (drives the bus and out_ack)
interface nios2vga_control_out_if #(parameter int DATA_WIDTH = 8);
   logic [2:0]            address;
   logic                  chipselect;
   logic                  write_n;
   logic [31:0]           writedata;
   logic [31:0]           readdata;
   logic [DATA_WIDTH-1:0] out_port;
   logic                  out_valid;
   logic                  out_ack;
   logic [DATA_WIDTH-1:0] out_pulse;
   modport slave (
      input  address, chipselect, write_n, writedata, out_ack,
      output readdata, out_port, out_valid, out_pulse
   );
   modport master (
      output address, chipselect, write_n, writedata, out_ack,
      input  readdata, out_port, out_valid, out_pulse
   );
endinterface

// File: rtl/nios2vga_control_out.sv
// nios2vga_control_out: Avalon-MM control register block driving a VGA control word and one-shot pulses.
//   clk      : single rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of nios2vga_control_out_if
//              registers 0 DATA (r/w), 1 STATUS (r), 2 PULSE (w), 4 OUTSET (w), 5 OUTCLEAR (w)
module nios2vga_control_out #(
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int                    PULSE_LEN   = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   nios2vga_control_out_if.slave   bus
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t                state;
   logic [7:0]            cnt;
   logic [DATA_WIDTH-1:0] mask;
   logic [DATA_WIDTH-1:0] wd;
   logic                  wr, wr_data, wr_set, wr_clr, wr_pulse, wr_port;
   assign wr       = bus.chipselect & ~bus.write_n;
   assign wd       = bus.writedata[DATA_WIDTH-1:0];
   assign wr_data  = wr && bus.address == 3'd0;
   assign wr_pulse = wr && bus.address == 3'd2;
   assign wr_set   = wr && bus.address == 3'd4;
   assign wr_clr   = wr && bus.address == 3'd5;
   assign wr_port  = wr_data | wr_set | wr_clr;
   // mask is held at zero whenever the FSM is idle, so it drives the pulse lines directly
   assign bus.out_pulse = mask;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.out_port  <= RESET_VALUE;
         bus.out_valid <= 1'b0;
         bus.readdata  <= '0;
      end else begin
         bus.out_port  <= wr_data ? wd : wr_set ? bus.out_port | wd : wr_clr ? bus.out_port & ~wd : bus.out_port;
         // a new change always wins over a simultaneous acknowledge
         bus.out_valid <= wr_port | (bus.out_valid & ~bus.out_ack);
         bus.readdata  <= bus.address == 3'd0 ? 32'(bus.out_port) :
                          bus.address == 3'd1 ? {30'b0, state == ACTIVE, bus.out_valid} : '0;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         mask  <= '0;
      end else if (wr_pulse && wd != '0) begin
         state <= ACTIVE;
         cnt   <= 8'(PULSE_LEN);
         mask  <= wd;
      end else if (state == ACTIVE && (wr_pulse || cnt == 8'd1)) begin
         // expiry on the last counted cycle, or abort by a zero-mask write
         state <= IDLE;
         cnt   <= '0;
         mask  <= '0;
      end else if (state == ACTIVE) begin
         cnt   <= cnt - 8'd1;
      end
   end
endmodule

// File: tb/tb_nios2vga_control_out.sv
// tb_nios2vga_control_out: random and directed stimulus checked every cycle against a behavioural model.
module tb_nios2vga_control_out;
   localparam int PL = 4;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   nios2vga_control_out_if #(.DATA_WIDTH(8)) bus ();
   nios2vga_control_out #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .PULSE_LEN(PL)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );
   // behavioural model: register contents plus "cycles of pulse left"
   logic [7:0]  m_port, m_mask;
   logic        m_valid;
   int          m_rem;
   logic [31:0] m_rd;
   wire         m_w = bus.chipselect && !bus.write_n;
   wire [2:0]   m_a = bus.address;
   wire [7:0]   m_d = bus.writedata[7:0];
   wire [7:0]   m_pulse = (m_rem > 0) ? m_mask : 8'h00;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_port  <= 8'h00;
         m_valid <= 1'b0;
         m_rem   <= 0;
         m_mask  <= 8'h00;
         m_rd    <= 32'h0;
      end else begin
         m_port  <= !m_w ? m_port : m_a == 0 ? m_d : m_a == 4 ? (m_port | m_d) : m_a == 5 ? (m_port & ~m_d) : m_port;
         m_valid <= (m_w && (m_a == 0 || m_a == 4 || m_a == 5)) || (m_valid && !bus.out_ack);
         m_rd    <= m_a == 0 ? {24'h0, m_port} : m_a == 1 ? {30'h0, m_rem > 0, m_valid} : 32'h0;
         if (m_w && m_a == 2) begin
            m_rem  <= (m_d != 0) ? PL : 0;
            m_mask <= m_d;
         end else if (m_rem > 0) begin
            m_rem  <= m_rem - 1;
         end
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (reset_n) begin
         chk("readdata", bus.readdata, m_rd);
         chk("out_port", 32'(bus.out_port), 32'(m_port));
         chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
         chk("out_pulse", 32'(bus.out_pulse), 32'(m_pulse));
      end
   end
   // apply one cycle of inputs at a falling edge and return at the next falling edge
   task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] d, input logic ak);
      bus.address    = a;
      bus.chipselect = cs;
      bus.write_n    = wn;
      bus.writedata  = d;
      bus.out_ack    = ak;
      @(negedge clk);
   endtask
   initial begin
      bus.address = 3'd0;
      bus.chipselect = 1'b0;
      bus.write_n = 1'b1;
      bus.writedata = 32'h0;
      bus.out_ack = 1'b0;
      @(negedge clk);
      chk("rst readdata", bus.readdata, 32'h0);
      chk("rst out_port", 32'(bus.out_port), 32'h0);
      chk("rst out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst out_pulse", 32'(bus.out_pulse), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      step(3'd0, 1'b1, 1'b0, 32'h0000_00A5, 1'b0);
      chk("data wr port", 32'(bus.out_port), 32'hA5);
      chk("data wr valid", 32'(bus.out_valid), 32'h1);
      step(3'd0, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("data read", bus.readdata, 32'h0000_00A5);
      step(3'd4, 1'b1, 1'b0, 32'h0A, 1'b0);
      chk("outset", 32'(bus.out_port), 32'hAF);
      step(3'd5, 1'b1, 1'b0, 32'h81, 1'b0);
      chk("outclear", 32'(bus.out_port), 32'h2E);
      chk("valid held", 32'(bus.out_valid), 32'h1);
      step(3'd1, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("status idle", bus.readdata, 32'h1);
      step(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
      chk("ack clears", 32'(bus.out_valid), 32'h0);
      step(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
      chk("ack no effect", 32'(bus.out_valid), 32'h0);
      step(3'd0, 1'b1, 1'b0, 32'h11, 1'b1);
      chk("write beats ack", 32'(bus.out_valid), 32'h1);
      step(3'd2, 1'b1, 1'b0, 32'h03, 1'b0);
      chk("pulse start", 32'(bus.out_pulse), 32'h03);
      chk("pulse keeps port", 32'(bus.out_port), 32'h11);
      for (int i = 0; i < 3; i++) begin
         step(3'd1, 1'b0, 1'b1, 32'h0, 1'b0);
         chk("pulse held", 32'(bus.out_pulse), 32'h03);
         chk("status busy", bus.readdata, 32'h3);
      end
      step(3'd1, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("pulse end", 32'(bus.out_pulse), 32'h00);
      step(3'd2, 1'b1, 1'b0, 32'h01, 1'b0);
      step(3'd0, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("pulse 01", 32'(bus.out_pulse), 32'h01);
      step(3'd2, 1'b1, 1'b0, 32'h02, 1'b0);
      for (int i = 0; i < 3; i++) step(3'd0, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("restart held", 32'(bus.out_pulse), 32'h02);
      step(3'd0, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("restart end", 32'(bus.out_pulse), 32'h00);
      step(3'd2, 1'b1, 1'b0, 32'h40, 1'b0);
      step(3'd2, 1'b1, 1'b0, 32'h00, 1'b0);
      chk("abort", 32'(bus.out_pulse), 32'h00);
      step(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
      step(3'd3, 1'b1, 1'b0, 32'hFF, 1'b0);
      step(3'd6, 1'b1, 1'b0, 32'hFF, 1'b0);
      step(3'd7, 1'b1, 1'b0, 32'h00, 1'b0);
      chk("reserved port", 32'(bus.out_port), 32'h11);
      chk("reserved valid", 32'(bus.out_valid), 32'h0);
      chk("reserved read", bus.readdata, 32'h0);
      for (int i = 0; i < 3000; i++)
         step(3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
              ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom), $urandom_range(0, 3) == 0);
      step(3'd0, 1'b1, 1'b0, 32'h5A, 1'b0);
      step(3'd2, 1'b1, 1'b0, 32'h0F, 1'b0);
      step(3'd0, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("pre-reset pulse", 32'(bus.out_pulse), 32'h0F);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async port", 32'(bus.out_port), 32'h0);
      chk("async valid", 32'(bus.out_valid), 32'h0);
      chk("async readdata", bus.readdata, 32'h0);
      chk("async pulse", 32'(bus.out_pulse), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      step(3'd0, 1'b1, 1'b0, 32'h33, 1'b0);
      chk("first edge", 32'(bus.out_port), 32'h33);
      step(3'd0, 1'b0, 1'b1, 32'h0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
